// File: rtl/ccm_pkg.sv
// Shared CCM definitions: geometry, requester ids and a one-hot decode helper.
package ccm_pkg;
  localparam int CCM_ADDR_WIDTH = 11;
  localparam int CCM_DATA_WIDTH = 32;

  localparam int REQ_IFU = 0;
  localparam int REQ_LSU = 1;
  localparam int REQ_DMA = 2;

  // Position of the set bit in a one-hot vector (up to 8 requesters); 0 when empty.
  function automatic logic [2:0] onehot2idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++)
      if (oh[i]) idx = 3'(i);
    return idx;
  endfunction
endpackage

// File: rtl/ccm_rr_arb.sv
// Round-robin picker: first requester at or above ptr (wrapping) wins.
module ccm_rr_arb #(
  parameter int NREQ = 3,
  parameter int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDXW-1:0] idx,
  output logic            any
);
  logic [IDXW-1:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDXW'((int'(ptr) + k) % NREQ);
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end
endmodule

// File: rtl/ccm_arbiter.sv
// CCM port arbiter: round-robin read port with tagged responses, fixed-priority write port.
// Define CCM_ARB_FWD_EN to forward the last write's data instead of stalling a RAW read.
module ccm_arbiter
  import ccm_pkg::*;
#(
  parameter int ADDR_WIDTH = CCM_ADDR_WIDTH,
  parameter int DATA_WIDTH = CCM_DATA_WIDTH,
  parameter int NREQ       = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            rd_req,
  input  logic [NREQ*ADDR_WIDTH-1:0] rd_addr,
  output logic [NREQ-1:0]            rd_gnt,
  output logic [NREQ-1:0]            rd_valid,
  output logic [DATA_WIDTH-1:0]      rd_data,
  input  logic [NREQ-1:0]            wr_req,
  input  logic [NREQ*ADDR_WIDTH-1:0] wr_addr,
  input  logic [NREQ*DATA_WIDTH-1:0] wr_data,
  output logic [NREQ-1:0]            wr_gnt,
  output logic                       cntlr_rd,
  output logic [ADDR_WIDTH-1:0]      cntlr_raddr,
  input  logic [DATA_WIDTH-1:0]      cntlr_rd_data,
  input  logic                       cntlr_rd_valid,
  output logic                       cntlr_wr,
  output logic [ADDR_WIDTH-1:0]      cntlr_waddr,
  output logic [DATA_WIDTH-1:0]      cntlr_wr_data
);
  localparam int IDXW = $clog2(NREQ);

  logic [NREQ-1:0][ADDR_WIDTH-1:0] rd_addr_v, wr_addr_v;
  logic [NREQ-1:0][DATA_WIDTH-1:0] wr_data_v;
  assign rd_addr_v = rd_addr;
  assign wr_addr_v = wr_addr;
  assign wr_data_v = wr_data;

  logic [IDXW-1:0]       rr_ptr, rd_idx, wr_idx;
  logic [NREQ-1:0]       arb_gnt, rsp_tag, wr_pick;
  logic [7:0]            wr_oh;
  logic                  rd_any, raw_match, rd_stall, rd_fire;
  logic                  last_wr_vld;
  logic [ADDR_WIDTH-1:0] last_wr_addr;

  ccm_rr_arb #(.NREQ(NREQ), .IDXW(IDXW)) u_rd_arb (
    .req (rd_req),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (rd_idx),
    .any (rd_any)
  );

  // The controller commits a write one cycle after issue, so a read of that
  // address in the following cycle would see stale data.
  assign cntlr_raddr = rd_addr_v[rd_idx];
  assign raw_match   = last_wr_vld && (cntlr_raddr == last_wr_addr);
`ifdef CCM_ARB_FWD_EN
  assign rd_stall = 1'b0;
`else
  assign rd_stall = raw_match;
`endif
  assign rd_fire  = rd_any && !rd_stall && !rst;
  assign rd_gnt   = rd_fire ? arb_gnt : '0;
  assign cntlr_rd = rd_fire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr  <= '0;
      rsp_tag <= '0;
    end else begin
      rsp_tag <= rd_gnt;
      if (rd_fire)
        rr_ptr <= (rd_idx == IDXW'(NREQ - 1)) ? '0 : rd_idx + IDXW'(1);
    end
  end

  assign rd_valid = rsp_tag & {NREQ{cntlr_rd_valid}};

  // Lowest set bit wins the write port.
  assign wr_pick       = wr_req & (~wr_req + NREQ'(1));
  assign wr_oh         = 8'(wr_pick);
  assign wr_idx        = IDXW'(onehot2idx(wr_oh));
  assign wr_gnt        = rst ? '0 : wr_pick;
  assign cntlr_wr      = |wr_gnt;
  assign cntlr_waddr   = wr_addr_v[wr_idx];
  assign cntlr_wr_data = wr_data_v[wr_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_wr_vld  <= 1'b0;
      last_wr_addr <= '0;
    end else begin
      last_wr_vld  <= cntlr_wr;
      last_wr_addr <= cntlr_waddr;
    end
  end

`ifdef CCM_ARB_FWD_EN
  logic                  fwd;
  logic [DATA_WIDTH-1:0] last_wr_data, fwd_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd          <= 1'b0;
      last_wr_data <= '0;
      fwd_data     <= '0;
    end else begin
      last_wr_data <= cntlr_wr_data;
      fwd          <= rd_fire && raw_match;
      if (rd_fire && raw_match) fwd_data <= last_wr_data;
    end
  end

  assign rd_data = fwd ? fwd_data : cntlr_rd_data;
`else
  assign rd_data = cntlr_rd_data;
`endif
endmodule

// File: tb/tb_ccm_arbiter.sv
// Bench for ccm_arbiter: directed scenarios plus a randomized run against a word-level model.
module tb_ccm_arbiter;
  localparam int AW = 11;
  localparam int DW = 32;
  localparam int N  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  rd_req = '0, wr_req = '0;
  logic [N*AW-1:0] rd_addr = '0, wr_addr = '0;
  logic [N*DW-1:0] wr_data = '0;
  logic [N-1:0]  rd_gnt, rd_valid, wr_gnt;
  logic [DW-1:0] rd_data, cntlr_wr_data;
  logic [DW-1:0] cntlr_rd_data = '0;
  logic          cntlr_rd, cntlr_wr;
  logic          cntlr_rd_valid = 1'b0;
  logic [AW-1:0] cntlr_raddr, cntlr_waddr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ccm_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NREQ(N)) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .cntlr_rd(cntlr_rd), .cntlr_raddr(cntlr_raddr),
    .cntlr_rd_data(cntlr_rd_data), .cntlr_rd_valid(cntlr_rd_valid),
    .cntlr_wr(cntlr_wr), .cntlr_waddr(cntlr_waddr), .cntlr_wr_data(cntlr_wr_data)
  );

  function automatic logic [DW-1:0] init_word(input int a);
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  // Controller: registered read (1-cycle valid), write committed one cycle after issue.
  logic [DW-1:0] mem [2048];
  logic          init_mem = 1'b1;
  logic          pend_vld = 1'b0;
  logic [AW-1:0] pend_addr = '0;
  logic [DW-1:0] pend_data = '0;

  always @(posedge clk) begin
    cntlr_rd_valid <= cntlr_rd;
    if (cntlr_rd) cntlr_rd_data <= mem[cntlr_raddr];
    pend_vld  <= cntlr_wr;
    pend_addr <= cntlr_waddr;
    pend_data <= cntlr_wr_data;
    if (init_mem) begin
      for (int i = 0; i < 2048; i++) mem[i] <= init_word(i);
    end else if (pend_vld) begin
      mem[pend_addr] <= pend_data;
    end
  end

  // Architectural memory contents as seen by the requesters.
  logic [DW-1:0] ref_mem [2048];

  task automatic drive_rd(input int i, input logic r, input logic [AW-1:0] a);
    rd_req[i] = r;
    rd_addr[i*AW +: AW] = a;
  endtask

  task automatic drive_wr(input int i, input logic r, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_req[i] = r;
    wr_addr[i*AW +: AW] = a;
    wr_data[i*DW +: DW] = d;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2048; i++) ref_mem[i] = init_word(i);
    rd_req = '1;
    wr_req = '1;
    @(negedge clk);
    checks++; if (rd_gnt !== '0) begin errors++; $display("FAIL reset_rd_gnt got %b exp 000", rd_gnt); end
    checks++; if (wr_gnt !== '0) begin errors++; $display("FAIL reset_wr_gnt got %b exp 000", wr_gnt); end
    checks++; if (cntlr_rd !== 1'b0 || cntlr_wr !== 1'b0) begin errors++; $display("FAIL reset_cntlr got rd=%b wr=%b exp 0 0", cntlr_rd, cntlr_wr); end
    checks++; if (rd_valid !== '0) begin errors++; $display("FAIL reset_rd_valid got %b exp 000", rd_valid); end
    rd_req = '0;
    wr_req = '0;
    next_cycle();
    rst = 1'b0;
    init_mem = 1'b0;
  endtask

  task automatic test_rr_rotation();
    logic [N-1:0] exp_g, prev_g;
    logic [AW-1:0] prev_a;
    prev_g = '0;
    prev_a = '0;
    drive_rd(0, 1'b1, 11'h010);
    drive_rd(1, 1'b1, 11'h020);
    drive_rd(2, 1'b1, 11'h030);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      exp_g = N'(1 << (c % N));
      checks++; if (rd_gnt !== exp_g) begin errors++; $display("FAIL rr_gnt c=%0d got %b exp %b", c, rd_gnt, exp_g); end
      if (c > 0) begin
        checks++; if (rd_valid !== prev_g) begin errors++; $display("FAIL rr_valid c=%0d got %b exp %b", c, rd_valid, prev_g); end
        checks++; if (rd_data !== ref_mem[prev_a]) begin errors++; $display("FAIL rr_data c=%0d got %h exp %h", c, rd_data, ref_mem[prev_a]); end
      end
      prev_g = exp_g;
      prev_a = AW'(16 * ((c % N) + 1));
      next_cycle();
    end
    rd_req = '0;
    @(negedge clk);
    checks++; if (rd_valid !== prev_g) begin errors++; $display("FAIL rr_valid_last got %b exp %b", rd_valid, prev_g); end
    checks++; if (rd_data !== ref_mem[prev_a]) begin errors++; $display("FAIL rr_data_last got %h exp %h", rd_data, ref_mem[prev_a]); end
    next_cycle();
  endtask

  task automatic test_wr_priority();
    drive_wr(1, 1'b1, 11'h100, 32'hA5A5A5A5);
    drive_wr(2, 1'b1, 11'h200, 32'h5A5A5A5A);
    @(negedge clk);
    checks++; if (wr_gnt !== 3'b010) begin errors++; $display("FAIL wr_prio_first got %b exp 010", wr_gnt); end
    checks++; if (cntlr_waddr !== 11'h100 || cntlr_wr_data !== 32'hA5A5A5A5) begin errors++; $display("FAIL wr_prio_lsu got %h/%h exp 100/a5a5a5a5", cntlr_waddr, cntlr_wr_data); end
    next_cycle();
    drive_wr(1, 1'b0, 11'h000, 32'h0);
    @(negedge clk);
    checks++; if (wr_gnt !== 3'b100) begin errors++; $display("FAIL wr_prio_second got %b exp 100", wr_gnt); end
    checks++; if (cntlr_waddr !== 11'h200 || cntlr_wr_data !== 32'h5A5A5A5A) begin errors++; $display("FAIL wr_prio_dma got %h/%h exp 200/5a5a5a5a", cntlr_waddr, cntlr_wr_data); end
    ref_mem[11'h100] = 32'hA5A5A5A5;
    ref_mem[11'h200] = 32'h5A5A5A5A;
    next_cycle();
    drive_wr(2, 1'b0, 11'h000, 32'h0);
    next_cycle();
    drive_rd(0, 1'b1, 11'h100);
    @(negedge clk);
    checks++; if (rd_gnt !== 3'b001) begin errors++; $display("FAIL wr_rb_gnt0 got %b exp 001", rd_gnt); end
    next_cycle();
    drive_rd(0, 1'b1, 11'h200);
    @(negedge clk);
    checks++; if (rd_valid !== 3'b001 || rd_data !== 32'hA5A5A5A5) begin errors++; $display("FAIL wr_rb_100 got %b/%h exp 001/a5a5a5a5", rd_valid, rd_data); end
    next_cycle();
    drive_rd(0, 1'b0, 11'h000);
    @(negedge clk);
    checks++; if (rd_valid !== 3'b001 || rd_data !== 32'h5A5A5A5A) begin errors++; $display("FAIL wr_rb_200 got %b/%h exp 001/5a5a5a5a", rd_valid, rd_data); end
    next_cycle();
  endtask

  task automatic test_raw();
    drive_wr(1, 1'b1, 11'h7FF, 32'hDEADBEEF);
    @(negedge clk);
    checks++; if (wr_gnt !== 3'b010) begin errors++; $display("FAIL raw_wr_gnt got %b exp 010", wr_gnt); end
    next_cycle();
    drive_wr(1, 1'b0, 11'h000, 32'h0);
    drive_rd(0, 1'b1, 11'h7FF);
    ref_mem[11'h7FF] = 32'hDEADBEEF;
`ifndef CCM_ARB_FWD_EN
    @(negedge clk);
    checks++; if (rd_gnt !== 3'b000 || cntlr_rd !== 1'b0) begin errors++; $display("FAIL raw_stall got gnt=%b rd=%b exp 000 0", rd_gnt, cntlr_rd); end
    next_cycle();
`endif
    @(negedge clk);
    checks++; if (rd_gnt !== 3'b001) begin errors++; $display("FAIL raw_gnt got %b exp 001", rd_gnt); end
    next_cycle();
    drive_rd(0, 1'b0, 11'h000);
    @(negedge clk);
    checks++; if (rd_valid !== 3'b001 || rd_data !== 32'hDEADBEEF) begin errors++; $display("FAIL raw_data got %b/%h exp 001/deadbeef", rd_valid, rd_data); end
    next_cycle();
  endtask

  task automatic test_same_cycle();
    drive_wr(2, 1'b1, 11'h040, 32'h11111111);
    @(negedge clk);
    checks++; if (wr_gnt !== 3'b100) begin errors++; $display("FAIL sc_pre_wr got %b exp 100", wr_gnt); end
    ref_mem[11'h040] = 32'h11111111;
    next_cycle();
    drive_wr(2, 1'b0, 11'h000, 32'h0);
    next_cycle();
    next_cycle();
    drive_rd(1, 1'b1, 11'h040);
    drive_wr(2, 1'b1, 11'h040, 32'h22222222);
    @(negedge clk);
    checks++; if (rd_gnt !== 3'b010 || wr_gnt !== 3'b100) begin errors++; $display("FAIL sc_gnts got rd=%b wr=%b exp 010 100", rd_gnt, wr_gnt); end
    next_cycle();
    drive_rd(1, 1'b0, 11'h000);
    drive_wr(2, 1'b0, 11'h000, 32'h0);
    @(negedge clk);
    checks++; if (rd_valid !== 3'b010 || rd_data !== 32'h11111111) begin errors++; $display("FAIL sc_old got %b/%h exp 010/11111111", rd_valid, rd_data); end
    ref_mem[11'h040] = 32'h22222222;
    next_cycle();
    drive_rd(1, 1'b1, 11'h040);
    @(negedge clk);
    checks++; if (rd_gnt !== 3'b010) begin errors++; $display("FAIL sc_late_gnt got %b exp 010", rd_gnt); end
    next_cycle();
    drive_rd(1, 1'b0, 11'h000);
    @(negedge clk);
    checks++; if (rd_valid !== 3'b010 || rd_data !== 32'h22222222) begin errors++; $display("FAIL sc_new got %b/%h exp 010/22222222", rd_valid, rd_data); end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    drive_rd(0, 1'b1, 11'h010);
    @(negedge clk);
    checks++; if (rd_gnt !== 3'b001) begin errors++; $display("FAIL rm_gnt got %b exp 001", rd_gnt); end
    next_cycle();
    rst = 1'b1;
    drive_rd(0, 1'b0, 11'h000);
    @(negedge clk);
    checks++; if (rd_valid !== 3'b000) begin errors++; $display("FAIL rm_dropped got %b exp 000", rd_valid); end
    next_cycle();
    rst = 1'b0;
    drive_rd(0, 1'b1, 11'h020);
    drive_rd(1, 1'b1, 11'h030);
    @(negedge clk);
    checks++; if (rd_gnt !== 3'b001) begin errors++; $display("FAIL rm_ptr got %b exp 001", rd_gnt); end
    checks++; if (rd_valid !== 3'b000) begin errors++; $display("FAIL rm_quiet got %b exp 000", rd_valid); end
    next_cycle();
    rd_req = '0;
    @(negedge clk);
    checks++; if (rd_valid !== 3'b001 || rd_data !== ref_mem[11'h020]) begin errors++; $display("FAIL rm_after got %b/%h exp 001/%h", rd_valid, rd_data, ref_mem[11'h020]); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 8; c++) begin
      drive_rd(2, 1'b1, AW'(c));
      @(negedge clk);
      checks++; if (rd_gnt !== 3'b100 || cntlr_rd !== 1'b1) begin errors++; $display("FAIL b2b_gnt c=%0d got %b exp 100", c, rd_gnt); end
      if (c > 0) begin
        checks++; if (rd_valid !== 3'b100 || rd_data !== ref_mem[c-1]) begin errors++; $display("FAIL b2b_rsp c=%0d got %b/%h exp 100/%h", c, rd_valid, rd_data, ref_mem[c-1]); end
      end
      next_cycle();
    end
    drive_rd(2, 1'b0, 11'h000);
    @(negedge clk);
    checks++; if (rd_valid !== 3'b100 || rd_data !== ref_mem[7]) begin errors++; $display("FAIL b2b_last got %b/%h exp 100/%h", rd_valid, rd_data, ref_mem[7]); end
    next_cycle();
  endtask

  // Randomized run on a tiny address window so collisions and RAW windows are common.
  task automatic test_random();
    int m_ptr, win, wwin, j;
    logic m_lw_vld, haz;
    logic [AW-1:0] m_lw_addr, ra, wa;
    logic [DW-1:0] wd, m_prev_data;
    logic [N-1:0] m_prev_gnt, exp_rg, exp_wg;
    rst = 1'b1;
    rd_req = '0;
    wr_req = '0;
    next_cycle();
    rst = 1'b0;
    m_ptr = 0; m_lw_vld = 1'b0; m_lw_addr = '0; m_prev_gnt = '0; m_prev_data = '0;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        drive_rd(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)));
        drive_wr(i, $urandom_range(0, 3) == 0, AW'($urandom_range(0, 3)), $urandom);
      end
      @(negedge clk);
      win = -1;
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (win < 0 && rd_req[j]) win = j;
      end
      ra = (win >= 0) ? rd_addr[win*AW +: AW] : '0;
      haz = 1'b0;
`ifndef CCM_ARB_FWD_EN
      if (win >= 0 && m_lw_vld && ra == m_lw_addr) haz = 1'b1;
`endif
      exp_rg = (win >= 0 && !haz) ? N'(1 << win) : '0;
      wwin = -1;
      for (int k = 0; k < N; k++) if (wwin < 0 && wr_req[k]) wwin = k;
      exp_wg = (wwin >= 0) ? N'(1 << wwin) : '0;
      wa = (wwin >= 0) ? wr_addr[wwin*AW +: AW] : '0;
      wd = (wwin >= 0) ? wr_data[wwin*DW +: DW] : '0;

      checks++; if (rd_gnt !== exp_rg) begin errors++; $display("FAIL rnd_rd_gnt c=%0d got %b exp %b", c, rd_gnt, exp_rg); end
      checks++; if (wr_gnt !== exp_wg) begin errors++; $display("FAIL rnd_wr_gnt c=%0d got %b exp %b", c, wr_gnt, exp_wg); end
      if (exp_rg != '0) begin
        checks++; if (cntlr_rd !== 1'b1 || cntlr_raddr !== ra) begin errors++; $display("FAIL rnd_raddr c=%0d got %b/%h exp 1/%h", c, cntlr_rd, cntlr_raddr, ra); end
      end
      if (exp_wg != '0) begin
        checks++; if (cntlr_waddr !== wa || cntlr_wr_data !== wd) begin errors++; $display("FAIL rnd_wr c=%0d got %h/%h exp %h/%h", c, cntlr_waddr, cntlr_wr_data, wa, wd); end
      end
      checks++; if (rd_valid !== m_prev_gnt) begin errors++; $display("FAIL rnd_valid c=%0d got %b exp %b", c, rd_valid, m_prev_gnt); end
      if (m_prev_gnt != '0) begin
        checks++; if (rd_data !== m_prev_data) begin errors++; $display("FAIL rnd_data c=%0d got %h exp %h", c, rd_data, m_prev_data); end
      end

      // A read observes every write issued in earlier cycles, never one in its own cycle.
      if (exp_rg != '0) begin
        m_prev_data = ref_mem[ra];
        m_ptr = (win + 1) % N;
      end
      m_prev_gnt = exp_rg;
      if (wwin >= 0) ref_mem[wa] = wd;
      m_lw_vld = (wwin >= 0);
      m_lw_addr = wa;
      next_cycle();
    end
    rd_req = '0;
    wr_req = '0;
    @(negedge clk);
    checks++; if (rd_valid !== m_prev_gnt) begin errors++; $display("FAIL rnd_valid_last got %b exp %b", rd_valid, m_prev_gnt); end
    if (m_prev_gnt != '0) begin
      checks++; if (rd_data !== m_prev_data) begin errors++; $display("FAIL rnd_data_last got %h exp %h", rd_data, m_prev_data); end
    end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_rr_rotation();
    test_wr_priority();
    test_raw();
    test_same_cycle();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
